// File: rtl/avg_unpool_layer_if.sv
// Start/done control and feature-map bus between the core sequencer and avg_unpool_layer.
// The master side drives start/input_fm; the slave side returns done/output_fm.
interface avg_unpool_layer_if #(
  parameter int DATA_W = 32,
  parameter int IN_W   = 3,
  parameter int IN_H   = 3
);
  logic                     start;
  logic signed [DATA_W-1:0] input_fm  [0:IN_W*IN_H-1];
  logic                     done;
  logic signed [DATA_W-1:0] output_fm [0:4*IN_W*IN_H-1];

  modport master (
    output start,
    output input_fm,
    input  done,
    input  output_fm
  );

  modport slave (
    input  start,
    input  input_fm,
    output done,
    output output_fm
  );
endinterface

// File: rtl/avg_unpool_layer.sv
// 2x2 average unpool: each pooled element /4 is scattered into its 2x2 output window.
// done rises 1 + 6*IN_W*IN_H edges after start is sampled; start only honoured in IDLE/DONE.
module avg_unpool_layer #(
  parameter int DATA_W     = 32,
  parameter int IN_W       = 3,
  parameter int IN_H       = 3,
  parameter int POOL_SHIFT = 2
) (
  input  logic               clk,
  input  logic               rst,
  avg_unpool_layer_if.slave  u_if
);
  localparam int N      = IN_W * IN_H;
  localparam int N_OUT  = 4 * N;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int OUT_AW = $clog2(N_OUT);

  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0]  IN_W_I     = IDX_W'(IN_W);
  localparam logic [OUT_AW-1:0] ROW_STRIDE = OUT_AW'(2 * IN_W);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_SCALE, S_SCATTER, S_NEXT, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic                     done_q, done_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [1:0]               q_q, q_d;
  logic signed [DATA_W-1:0] scaled_q, scaled_d;
  logic signed [DATA_W-1:0] in_buf_q [0:N-1];
  logic signed [DATA_W-1:0] in_buf_d [0:N-1];
  logic signed [DATA_W-1:0] out_q    [0:N_OUT-1];
  logic signed [DATA_W-1:0] out_d    [0:N_OUT-1];

  logic [IDX_W-1:0]  row, col;
  logic [OUT_AW-1:0] base, wr_addr;

  // Top-left corner of the 2x2 window, then step right (q[0]) and down (q[1]).
  always_comb begin
    row     = idx_q / IN_W_I;
    col     = idx_q % IN_W_I;
    base    = ((OUT_AW'(row) * ROW_STRIDE) << 1) + (OUT_AW'(col) << 1);
    wr_addr = base + (q_q[1] ? ROW_STRIDE : '0) + OUT_AW'(q_q[0]);
  end

  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    idx_d    = idx_q;
    q_d      = q_q;
    scaled_d = scaled_q;
    in_buf_d = in_buf_q;
    out_d    = out_q;
    case (state_q)
      S_IDLE: begin
        if (u_if.start) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        in_buf_d = u_if.input_fm;
        idx_d    = '0;
        state_d  = S_SCALE;
      end
      S_SCALE: begin
        scaled_d = in_buf_q[idx_q] >>> POOL_SHIFT;
        q_d      = '0;
        state_d  = S_SCATTER;
      end
      S_SCATTER: begin
        out_d[wr_addr] = scaled_q;
        q_d            = q_q + 2'd1;
        if (q_q == 2'd3) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_SCALE;
        end
      end
      S_DONE: begin
        if (u_if.start) begin
          done_d  = 1'b0;
          state_d = S_CAPTURE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      idx_q    <= '0;
      q_q      <= '0;
      scaled_q <= '0;
      for (int i = 0; i < N; i++)     in_buf_q[i] <= '0;
      for (int i = 0; i < N_OUT; i++) out_q[i]    <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      idx_q    <= idx_d;
      q_q      <= q_d;
      scaled_q <= scaled_d;
      in_buf_q <= in_buf_d;
      out_q    <= out_d;
    end
  end

  assign u_if.done      = done_q;
  assign u_if.output_fm = out_q;
endmodule

// File: doc/avg_unpool_layer.md
Name: avg_unpool_layer

Overview:
Backward/expansion counterpart of the 2x2 average pooling layer in the CNN core. Takes a 3x3 pooled feature map (or pooled-map gradient) and scatters each element, divided by 4, into its 2x2 window of a 6x6 output map. This gives the average-pooling backward pass and an upsampling path. It uses the same start/done control style as the other cnn_core layers and is driven by the core sequencer.

Parameters:
DATA_W, 32, signed element width for input and output
IN_W, 3, pooled map width (output width = 2*IN_W)
IN_H, 3, pooled map height (output height = 2*IN_H)
POOL_SHIFT, 2, log2 of pool window area (2x2 = 4)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  begin operation; sampled only in IDLE or DONE
input_fm  input  DATA_W x (IN_W*IN_H), signed unpacked array [0:8]  pooled map, row-major
done  output  1  registered; high when output_fm is complete and valid
output_fm  output  DATA_W x (4*IN_W*IN_H), signed unpacked array [0:35], registered  expanded map, row-major

Behaviour:
- Clocking and reset: one clock domain; reset is synchronous and active-high.
- Reset values: state=IDLE, done=0, every output_fm entry=0, idx=0, q=0.
- Reset mid-operation aborts the run. All outputs clear on the same edge. No partial results are kept.
- FSM states: IDLE, CAPTURE, SCALE, SCATTER, NEXT, DONE.
- IDLE:
  - start=1 -> go to CAPTURE.
  - start=0 -> stay in IDLE.
- CAPTURE:
  - Latch all of input_fm into the internal buffer in_buf[0:8].
  - Set idx=0, then go to SCALE.
  - input_fm is ignored after this edge; changes mid-run have no effect.
- SCALE:
  - scaled <= in_buf[idx] >>> POOL_SHIFT. This is an arithmetic shift, i.e. floor division by 4, so -5 -> -2 and -1 -> -1.
  - Set q=0, then go to SCATTER.
- SCATTER, one write per cycle:
  - Index terms: r = idx / IN_W, c = idx % IN_W, base = (2r)*(2*IN_W) + 2c.
  - Write order: q=0 -> output_fm[base]; q=1 -> [base+1]; q=2 -> [base+2*IN_W]; q=3 -> [base+2*IN_W+1].
  - Increment q each cycle. After the q=3 write, go to NEXT.
- NEXT:
  - idx == IN_W*IN_H-1 -> go to DONE and set done<=1 on the same edge.
  - Otherwise idx++ and go to SCALE.
- DONE:
  - Hold done=1 and output_fm stable.
  - start=1 -> done<=0 and go to CAPTURE. This gives a back-to-back restart.
- Starts outside IDLE/DONE: start asserted in CAPTURE, SCALE, SCATTER or NEXT is ignored. It is neither queued nor restarts the run.
- Output contents during a run: output_fm entries not yet written keep their prior values (0 after reset, or the previous run's values). Consumers read only when done=1.
- Latency, counting edges from the edge that samples start (edge 0):
  - CAPTURE at edge 1.
  - Then 6 edges per element: SCALE + 4 SCATTER + NEXT.
  - done rises at edge 1 + 6*9 = 55 for default parameters.
  - General formula: 1 + 6*IN_W*IN_H.
- Arithmetic width: no width growth, since a shift cannot overflow. Internal index counters are sized for IN_W*IN_H and a 2-bit q.

Test Plan:
1. Reset/idle: assert rst for 2 cycles, start=0 for 10 cycles -> done=0 and all 36 output_fm entries are 0 throughout.
2. Ramp mapping: input_fm[k] = 4*(k+1) for k = 0..8, pulse start -> done rises exactly at edge 55.
   - output_fm[0,1,6,7] = 1; [2,3,8,9] = 2; [28,29,34,35] = 9.
   - All 36 entries checked against the index formula.
3. Negative rounding: input_fm = {-5, -1, -4, 7, 3, -8, 0, 2147483647, -2147483648}.
   - Quadrant values: -2, -1, -1, 1, 0, -2, 0, 536870911, -536870912.
4. Input isolation and busy start: start a run, then change input_fm to all 100 and pulse start at edge 20.
   - Run completes at edge 55 with the original captured results; no restart occurs.
5. Reset mid-run: start with all inputs 40, assert rst at edge 30 for 1 cycle -> done=0 and all outputs 0 on the next edge.
   - A fresh start then produces all 36 entries = 10, with done at edge 55 after the new start.
6. Back-to-back: after done, hold start=1 with new input all -8 -> done drops the next edge.
   - done rises again 55 edges after the restart edge, with all entries = -2.
